// File: rtl/accumulator_arbiter.sv
// Round-robin arbiter that grants one requester a burst and sums its operands into a single result.
// Latency: grant one cycle after req seen in IDLE; result one cycle after the last accepted beat.
// Backpressure: in_valid low stalls the burst indefinitely; out_ready low holds the result and the grant.
//
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   req, req_len            per-requester request level and burst length (LEN_W bits each)
//   grant                   one-hot owner of the block, zero when idle
//   in_valid/in_ready/in_data   operand stream from the granted requester
//   out_valid/out_ready     result handshake
//   out_data/out_id/out_overflow   wrapped sum, owner index, sticky carry-out
//   busy                    high whenever a burst is in progress or its result is pending
module accumulator_arbiter #(
   parameter int  DATA_W  = 16,
   parameter int  NUM_REQ = 4,
   parameter int  LEN_W   = 4,
   localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*LEN_W-1:0] req_len,
   output logic [NUM_REQ-1:0]       grant,
   input  logic                     in_valid,
   input  logic [DATA_W-1:0]        in_data,
   output logic                     in_ready,
   output logic                     out_valid,
   output logic [DATA_W-1:0]        out_data,
   output logic [ID_W-1:0]          out_id,
   output logic                     out_overflow,
   input  logic                     out_ready,
   output logic                     busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t            state_q;
   state_t            state_d;
   logic [DATA_W-1:0] acc;
   logic              ovf;
   logic [LEN_W-1:0]  cnt;
   logic [ID_W-1:0]   last_winner;

   logic              pick_found;
   logic [ID_W-1:0]   pick_idx;
   logic [LEN_W-1:0]  pick_len;
   logic [DATA_W:0]   sum_ext;

   // Rotating priority: search upward starting just past the previous winner,
   // so a requester that keeps req high yields to everyone else first.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         if (!pick_found && req[(int'(last_winner) + k) % NUM_REQ]) begin
            pick_found = 1'b1;
            pick_idx   = ID_W'((int'(last_winner) + k) % NUM_REQ);
         end
      end
   end

   assign pick_len = req_len[int'(pick_idx)*LEN_W +: LEN_W];

   // One extra bit captures the carry-out of each addition.
   assign sum_ext = {1'b0, acc} + {1'b0, in_data};

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (pick_found) begin
               state_d = (pick_len != '0) ? ACCUM : DONE;
            end
         end
         ACCUM: begin
            if (in_valid && (cnt == LEN_W'(1))) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         grant       <= '0;
         out_id      <= '0;
         acc         <= '0;
         ovf         <= 1'b0;
         cnt         <= '0;
         last_winner <= ID_W'(NUM_REQ - 1);
      end else begin
         case (state_q)
            IDLE: begin
               if (pick_found) begin
                  grant  <= NUM_REQ'(1) << pick_idx;
                  out_id <= pick_idx;
                  acc    <= '0;
                  ovf    <= 1'b0;
                  cnt    <= pick_len;
               end
            end
            ACCUM: begin
               if (in_valid) begin
                  acc <= sum_ext[DATA_W-1:0];
                  ovf <= ovf | sum_ext[DATA_W];
                  cnt <= cnt - LEN_W'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  grant       <= '0;
                  last_winner <= out_id;
               end
            end
            default: begin
               grant <= '0;
            end
         endcase
      end
   end

   assign in_ready     = (state_q == ACCUM);
   assign out_valid    = (state_q == DONE);
   assign busy         = (state_q != IDLE);
   assign out_data     = acc;
   assign out_overflow = ovf;

endmodule

// File: tb/tb_accumulator_arbiter.sv
// Bench for accumulator_arbiter: directed scenarios followed by randomized traffic.
// Latency: a transaction-level model predicts the outputs after every rising edge.
// Backpressure: in_valid and out_ready are driven both as fixed patterns and at random.
module tb_accumulator_arbiter;

   localparam int N = 4;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic [N-1:0]  req = '0;
   logic [N*4-1:0] req_len = '0;
   logic [N-1:0]  grant;
   logic          in_valid = 1'b0;
   logic [15:0]   in_data = '0;
   logic          in_ready;
   logic          out_valid;
   logic [15:0]   out_data;
   logic [1:0]    out_id;
   logic          out_overflow;
   logic          out_ready = 1'b0;
   logic          busy;

   int total = 0;
   int bad   = 0;

   // Transaction-level model: who owns the block, how many beats remain,
   // and the true (unbounded) sum of the beats accepted so far.
   int     m_owner = -1;
   int     m_rem   = 0;
   longint m_total = 0;
   bit     m_done  = 0;
   int     m_last  = N - 1;
   int     m_id    = 0;
   bit     m_jr    = 0;
   bit     m_ok    = 0;

   accumulator_arbiter dut (
      .clock       (clock),
      .reset       (reset),
      .req         (req),
      .req_len     (req_len),
      .grant       (grant),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_ready    (in_ready),
      .out_valid   (out_valid),
      .out_data    (out_data),
      .out_id      (out_id),
      .out_overflow(out_overflow),
      .out_ready   (out_ready),
      .busy        (busy)
   );

   always #5 clock = ~clock;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; req = '0; req_len = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   // Waits for grant to change away from its current value, counts cycles
   // spent with no grant, then checks the new owner and (optionally) that
   // exactly one idle cycle separated the two grants.
   task automatic next_grant(input logic [N-1:0] exp, input string nm, input bit chk_gap);
      logic [N-1:0] prev;
      int zeros;
      int n;
      prev = grant; zeros = 0; n = 0;
      while (grant == prev && n < 60) begin tick(); n++; end
      while (grant == '0 && n < 60) begin zeros++; tick(); n++; end
      if (n >= 60) begin
         total++; bad++;
         $display("FAIL %s: timeout waiting for grant, got %0h expected %0h", nm, grant, exp);
      end else begin
         chk(nm, 32'(grant), 32'(exp));
         if (chk_gap) chk({nm, "_gap"}, zeros, 1);
      end
   endtask

   // Model update on every rising edge, from the inputs as the DUT sees them.
   initial begin
      forever begin
         @(posedge clock);
         if (reset) begin
            m_owner = -1; m_rem = 0; m_total = 0; m_done = 0;
            m_last = N - 1; m_id = 0; m_jr = 1; m_ok = 1;
         end else if (m_ok) begin
            if (m_owner < 0) begin
               for (int k = 1; k <= N; k++) begin
                  if (m_owner < 0 && req[(m_last + k) % N]) begin
                     m_owner = (m_last + k) % N;
                     m_id    = m_owner;
                     m_total = 0;
                     m_rem   = int'(req_len[m_owner*4 +: 4]);
                     m_done  = (m_rem == 0);
                     m_jr    = 0;
                  end
               end
            end else if (!m_done) begin
               if (in_valid) begin
                  m_total += longint'(in_data);
                  m_rem--;
                  if (m_rem == 0) m_done = 1;
               end
            end else if (out_ready) begin
               m_last  = m_owner;
               m_owner = -1;
               m_done  = 0;
            end
         end
      end
   end

   // Compare every cycle, away from the active edge.
   initial begin
      forever begin
         @(negedge clock);
         if (m_ok) begin
            chk("m_grant", 32'(grant), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
            chk("m_in_ready", 32'(in_ready), 32'(m_owner >= 0 && !m_done));
            chk("m_out_valid", 32'(out_valid), 32'(m_done));
            chk("m_busy", 32'(busy), 32'(m_owner >= 0));
            if (m_done || m_jr) begin
               chk("m_out_data", 32'(out_data), 32'(m_total % 65536));
               chk("m_out_id", 32'(out_id), 32'(m_id));
               chk("m_out_ovf", 32'(out_overflow), 32'(m_total >= 65536));
            end
         end
      end
   end

   initial begin
      // Reset state
      do_reset();
      chk("rst_grant", 32'(grant), 0);
      chk("rst_in_ready", 32'(in_ready), 0);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_data", 32'(out_data), 0);
      chk("rst_out_id", 32'(out_id), 0);
      chk("rst_ovf", 32'(out_overflow), 0);
      chk("rst_busy", 32'(busy), 0);

      // Single burst of 1+2+3
      req = 4'b0001; req_len = 16'h0003; out_ready = 1'b1;
      next_grant(4'b0001, "s1_grant", 0);
      chk("s1_in_ready", 32'(in_ready), 1);
      req = '0; in_valid = 1'b1;
      in_data = 16'h0001; tick();
      in_data = 16'h0002; tick();
      in_data = 16'h0003; tick();
      in_valid = 1'b0;
      chk("s1_out_valid", 32'(out_valid), 1);
      chk("s1_out_data", 32'(out_data), 32'h0006);
      chk("s1_out_id", 32'(out_id), 0);
      chk("s1_ovf", 32'(out_overflow), 0);
      tick();
      chk("s1_grant_clr", 32'(grant), 0);
      chk("s1_out_valid_clr", 32'(out_valid), 0);

      // Round-robin with everyone requesting
      do_reset();
      req = 4'b1111; req_len = 16'h1111; in_valid = 1'b1; in_data = 16'h0010; out_ready = 1'b1;
      next_grant(4'b0001, "rr0", 0);
      next_grant(4'b0010, "rr1", 1);
      next_grant(4'b0100, "rr2", 1);
      next_grant(4'b1000, "rr3", 1);
      next_grant(4'b0001, "rr4", 1);
      req = '0; in_valid = 1'b0;
      tick(); tick();

      // Wrap past 0xFFFF
      do_reset();
      req = 4'b0001; req_len = 16'h0002;
      next_grant(4'b0001, "w_grant", 0);
      req = '0; in_valid = 1'b1;
      in_data = 16'hFFFF; tick();
      in_data = 16'h0002; tick();
      in_valid = 1'b0;
      chk("w_out_valid", 32'(out_valid), 1);
      chk("w_out_data", 32'(out_data), 32'h0001);
      chk("w_ovf", 32'(out_overflow), 1);
      out_ready = 1'b1; tick();
      chk("w_out_valid_clr", 32'(out_valid), 0);

      // Input stall then result backpressure; req changes meanwhile are ignored
      do_reset();
      req = 4'b0010; req_len = 16'h0020;
      next_grant(4'b0010, "st_grant", 0);
      req = 4'b1101; req_len = 16'hFFFF; in_valid = 1'b1; in_data = 16'h1234; tick();
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("st_hold_in_ready", 32'(in_ready), 1);
         chk("st_hold_grant", 32'(grant), 32'b0010);
         chk("st_hold_no_valid", 32'(out_valid), 0);
      end
      in_valid = 1'b1; in_data = 16'h0100; tick();
      in_valid = 1'b0;
      chk("st_out_data", 32'(out_data), 32'h1334);
      chk("st_out_id", 32'(out_id), 1);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("st_bp_valid", 32'(out_valid), 1);
         chk("st_bp_data", 32'(out_data), 32'h1334);
         chk("st_bp_grant", 32'(grant), 32'b0010);
      end
      req = '0; out_ready = 1'b1; tick();
      chk("st_grant_clr", 32'(grant), 0);
      chk("st_valid_clr", 32'(out_valid), 0);

      // Zero-length burst: no beat may be accepted even with in_valid high
      do_reset();
      req = 4'b0100; req_len = 16'h0000; in_valid = 1'b1; in_data = 16'h5555;
      next_grant(4'b0100, "z_grant", 0);
      chk("z_in_ready", 32'(in_ready), 0);
      chk("z_out_valid", 32'(out_valid), 1);
      chk("z_out_data", 32'(out_data), 0);
      chk("z_out_id", 32'(out_id), 2);
      chk("z_ovf", 32'(out_overflow), 0);
      req = '0; in_valid = 1'b0; out_ready = 1'b1; tick();
      chk("z_grant_clr", 32'(grant), 0);

      // Reset in the middle of a burst
      do_reset();
      req = 4'b0001; req_len = 16'h0003; out_ready = 1'b1;
      next_grant(4'b0001, "rm_grant", 0);
      req = 4'b0010; in_valid = 1'b1; in_data = 16'h0007; tick();
      in_valid = 1'b0; reset = 1'b1; tick();
      reset = 1'b0;
      chk("rm_grant_zero", 32'(grant), 0);
      chk("rm_in_ready", 32'(in_ready), 0);
      chk("rm_out_valid", 32'(out_valid), 0);
      chk("rm_out_data", 32'(out_data), 0);
      chk("rm_out_id", 32'(out_id), 0);
      chk("rm_ovf", 32'(out_overflow), 0);
      chk("rm_busy", 32'(busy), 0);
      req = 4'b1111; req_len = 16'h1111; in_valid = 1'b1; in_data = 16'h0001;
      next_grant(4'b0001, "rm_first", 0);
      req = '0; in_valid = 1'b0;
      tick(); tick(); tick();

      // Randomized traffic, checked by the model every cycle
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         req       = N'($urandom_range(0, 15));
         req_len   = 16'($urandom) & 16'h3333;
         if ($urandom_range(0, 9) == 0) req_len = 16'($urandom);
         in_valid  = ($urandom_range(0, 9) < 7);
         in_data   = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom_range(0, 255));
         out_ready = ($urandom_range(0, 1) == 0);
         reset     = ($urandom_range(0, 199) == 0);
         tick();
      end
      reset = 1'b0; req = '0; in_valid = 1'b0;
      tick(); tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
